// File: rtl/mlu_pkg.sv
// mlu_pkg: shared FSM states, opcodes and iteration count for the MLU
package mlu_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_MUL = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;
  localparam logic [2:0] OP_DIV = 3'd7;
  localparam int ITER_CNT = 3;
endpackage

// File: rtl/mlu_iter_unit.sv
// mlu_iter_unit: shared shift-add multiplier / restoring divider (divider built only with MLU_DIV_EN)
module mlu_iter_unit #(
  parameter int W = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           step,
  input  logic           div,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] res
);
  logic [2*W-1:0] acc_q, acc_d, x_q, x_d, div_next;
  logic [W-1:0]   y_q, y_d;
`ifdef MLU_DIV_EN
  logic [W:0] sh, diff;
  logic       ge;
  assign sh       = {acc_q[2*W-1:W], acc_q[W-1]};
  assign ge       = sh >= {1'b0, y_q};
  assign diff     = sh - {1'b0, y_q};
  assign div_next = {ge ? diff[W-1:0] : sh[W-1:0], acc_q[W-2:0], ge};
`else
  assign div_next = acc_q;
`endif
  assign res = acc_d;
  // load seeds acc ({rem,quo} for divide, product for multiply); step runs one iteration
  always_comb begin
    acc_d = acc_q;
    x_d   = x_q;
    y_d   = y_q;
    if (load) begin
      acc_d = div ? {{W{1'b0}}, a} : '0;
      x_d   = {{W{1'b0}}, a};
      y_d   = b;
    end else if (step) begin
      acc_d = div ? div_next : acc_q + (y_q[0] ? x_q : '0);
      x_d   = div ? x_q : x_q << 1;
      y_d   = div ? y_q : y_q >> 1;
    end
  end
  // iteration registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      x_q   <= '0;
      y_q   <= '0;
    end else begin
      acc_q <= acc_d;
      x_q   <= x_d;
      y_q   <= y_d;
    end
  end
endmodule

// File: rtl/mlu_core.sv
// mlu_core: multi-cycle ALU, IDLE/CALC/DONE FSM; opcode 7 divides only with MLU_DIV_EN
module mlu_core import mlu_pkg::*; #(
  parameter int DATA_W = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [DATA_W-1:0]   A,
  input  logic [DATA_W-1:0]   B,
  input  logic [DATA_W-1:0]   N,
  output logic [2*DATA_W-1:0] result,
  output logic                ready
);
  localparam int RW = 2 * DATA_W;
  state_t            state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, n_q, n_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [RW-1:0]     result_q, result_d, alu, iter_res, ax, bx;
  logic              multi, load, step, div;
`ifdef MLU_DIV_EN
  assign multi = (n_q == OP_MUL) || (n_q == OP_DIV);
`else
  assign multi = n_q == OP_MUL;
`endif
  assign div    = load ? (N == OP_DIV) : (n_q == OP_DIV);
  assign ax     = RW'(a_q);
  assign bx     = RW'(b_q);
  assign result = result_q;
  assign ready  = state_q == DONE;
  mlu_iter_unit #(.W(DATA_W)) u_iter (
    .clk(clk), .rst(reset), .load(load), .step(step), .div(div),
    .a(A), .b(B), .res(iter_res)
  );
  // single-cycle ops; opcode 7 falls through to zero when the divider is absent
  always_comb begin
    alu = n_q == OP_ADD ? ax + bx :
          n_q == OP_SUB ? ax - bx :
          n_q == OP_AND ? ax & bx :
          n_q == OP_OR  ? ax | bx :
          n_q == OP_XOR ? ax ^ bx :
          n_q == OP_SHL ? ax << b_q : '0;
  end
  // next state, operand capture and result load on entry to DONE
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    n_d      = n_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    load     = 1'b0;
    step     = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = CALC;
        a_d     = A;
        b_d     = B;
        n_d     = N;
        cnt_d   = '0;
        load    = 1'b1;
      end
      CALC: begin
        step  = multi;
        cnt_d = cnt_q + 2'd1;
        if (!multi || cnt_q == 2'(ITER_CNT - 1)) begin
          state_d  = DONE;
          result_d = multi ? iter_res : alu;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      n_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      n_q      <= n_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end
endmodule

// File: tb/tb_mlu_core.sv
// tb_mlu_core: scoreboard bench for mlu_core (expectations follow MLU_DIV_EN)
module tb_mlu_core;
  logic       clk, reset, start, ready;
  logic [2:0] A, B, N;
  logic [5:0] result;
  int         n_cmp, n_err;
  int         q[$];

  mlu_core dut (
    .clk(clk), .reset(reset), .start(start), .A(A), .B(B), .N(N),
    .result(result), .ready(ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int model(int a, int b, int n);
    case (n)
      0: return a + b;
      1: return (a - b) & 63;
      2: return a & b;
      3: return a | b;
      4: return a * b;
      5: return a ^ b;
      6: return (a << b) & 63;
`ifdef MLU_DIV_EN
      default: return (b == 0) ? (a * 8 + 7) : ((a % b) * 8 + a / b);
`else
      default: return 0;
`endif
    endcase
  endfunction

  function automatic int exp_lat(int n);
`ifdef MLU_DIV_EN
    return (n == 4 || n == 7) ? 4 : 2;
`else
    return (n == 4) ? 4 : 2;
`endif
  endfunction

  always @(negedge clk) begin
    if (ready === 1'b1) begin
      if (q.size() == 0) chk("spurious_ready", 32'(ready), 0);
      else chk("result", 32'(result), 32'(q.pop_front()));
    end
  end

  task automatic op(input int a, input int b, input int n, input bit glitch);
    int lat;
    bit done;
    @(negedge clk);
    A = 3'(a); B = 3'(b); N = 3'(n); start = 1'b1;
    q.push_back(model(a, b, n));
    @(posedge clk);
    #1 start = 1'b0;
    if (glitch) begin
      A = 3'd7; B = 3'd7; N = 3'd0; start = 1'b1;
    end
    lat = 1;
    done = 1'b0;
    for (int c = 0; c < 12 && !done; c++) begin
      @(posedge clk);
      #1;
      lat++;
      start = 1'b0;
      if (ready) done = 1'b1;
    end
    chk("latency", done ? lat : -1, exp_lat(n));
    @(posedge clk);
  endtask

  initial begin
    int seen;
    n_cmp = 0; n_err = 0;
    reset = 1'b1; start = 1'b0; A = '0; B = '0; N = '0;
    #1;
    chk("rst_result_a", 32'(result), 0);
    chk("rst_ready_a", 32'(ready), 0);
    #8;
    chk("rst_result_b", 32'(result), 0);
    chk("rst_ready_b", 32'(ready), 0);
    #1;
    reset = 1'b0; A = 3'd5; B = 3'd5; N = 3'd4; start = 1'b1;
    repeat (3) q.push_back(25);
    @(posedge clk);
    seen = 0;
    for (int c = 2; c <= 18 && seen < 3; c++) begin
      @(posedge clk);
      #1;
      if (ready) begin
        chk("b2b_lat", c, 4 + 5 * seen);
        seen++;
        if (seen == 3) start = 1'b0;
      end
    end
    if (seen != 3) chk("b2b_count", seen, 3);
    start = 1'b0;
    @(posedge clk);
    op(7, 7, 0, 0);
    op(2, 5, 1, 0);
    op(6, 3, 2, 0);
    op(4, 3, 3, 0);
    op(5, 3, 5, 0);
    op(5, 3, 6, 0);
    op(7, 7, 6, 0);
    op(7, 7, 4, 0);
    op(6, 5, 4, 0);
    op(7, 2, 7, 0);
    op(5, 0, 7, 0);
    op(3, 5, 4, 1);
    op(2, 6, 1, 1);
    op(0, 6, 4, 0);
    @(negedge clk);
    A = 3'd6; B = 3'd6; N = 3'd4; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    #2;
    chk("abort_ready", 32'(ready), 0);
    chk("abort_result", 32'(result), 0);
    #2 reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("abort_no_ready", 32'(ready), 0);
    end
    op(1, 2, 0, 0);
    repeat (3) @(negedge clk);
    chk("pending", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mlu_core.md
Name: mlu_core

Overview:
Small multi-cycle arithmetic/logic unit ("MLU") for the FPGA demo top level. Captures two 3-bit operands and a 3-bit opcode on a start request, then computes over one or three cycles. Returns a 6-bit result with a one-cycle ready pulse. Simple ops take one compute cycle; multiply and divide are iterative (shift-add, restoring).

Parameters:
- DATA_W, 3, operand and opcode width; result width is 2*DATA_W. Only 3 is verified.

Ports:
- clk    input   1  system clock, rising edge
- reset  input   1  asynchronous, active-high reset
- start  input   1  operation request, level-sampled in IDLE
- A      input   3  operand A, unsigned
- B      input   3  operand B, unsigned
- N      input   3  opcode
- result output  6  registered result; holds until the next completion
- ready  output  1  one-cycle pulse: result updated this cycle

Behaviour:
- One clock. Reset is asynchronous and active-high.
- Reset: state=IDLE, result=0, ready=0, internal registers cleared. Reset mid-operation aborts the operation; result is not updated.
- States are IDLE, CALC, DONE.
- IDLE: on a rising edge with start=1, latch A, B, N into internal registers and go to CALC. Operand changes after capture are ignored.
- CALC: 1 cycle for opcodes 0-3, 5, 6; 3 cycles for opcodes 4 and 7, using a 2-bit iteration counter. Then go to DONE.
- DONE: result register loaded at the entry edge; ready=1 for exactly this cycle; next state is IDLE.
- start held high gives back-to-back operations: IDLE samples start again in the cycle after DONE.
- Latency from the capturing edge to the ready cycle: 2 cycles for simple ops, 4 for MUL/DIV. Period with start held high: 3 cycles simple, 5 MUL/DIV.
- Opcodes (operands zero-extended to 6 bits):
  - 0 ADD: A+B.
  - 1 SUB: A-B, 6-bit two's-complement wrap.
  - 2 AND: {3'b0, A&B}.
  - 3 OR: {3'b0, A|B}.
  - 4 MUL: A*B, shift-add over 3 iterations, LSB of B first; max 49, no overflow.
  - 5 XOR: {3'b0, A^B}.
  - 6 SHL: (A<<B) truncated to 6 bits.
  - 7 DIV: restoring division over 3 iterations; result = {remainder[2:0], quotient[2:0]}. If B=0, quotient=7 and remainder=A.
- start is ignored outside IDLE. ready never asserts without a prior capture.

Optional Feature:
- Macro MLU_DIV_EN.
- Defined: opcode 7 performs DIV as specified above.
- Undefined: divider logic is not built. Opcode 7 takes the 1-cycle CALC path with result=6'd0.

Decomposition:
- Package mlu_pkg holds:
  - state enum: IDLE, CALC, DONE
  - opcode localparams: OP_ADD=0, OP_SUB=1, OP_AND=2, OP_OR=3, OP_MUL=4, OP_XOR=5, OP_SHL=6, OP_DIV=7
  - ITER_CNT=3
- One natural sub-module: mlu_iter_unit, the shared shift-add multiplier / restoring divider datapath. It is controlled by the FSM in mlu_core.

Test Plan:
- Reset held 10 ns with start=0 -> result=0, ready=0 throughout. Assert reset mid-MUL -> state IDLE, result unchanged, no ready pulse.
- A=5, B=5, N=4, reset released, start held high -> first ready 4 cycles after capture, result=6'd25; ready repeats every 5 cycles with result 25.
- ADD A=7, B=7 -> 6'd14 after 2 cycles. SUB A=2, B=5 -> 6'b111101. AND A=6, B=3 -> 6'd2.
- SHL A=5, B=3 -> 6'd40. SHL A=7, B=7 -> 6'd0.
- DIV A=7, B=2 -> 6'b001_011 (r=1, q=3). DIV A=5, B=0 -> 6'b101_111. With MLU_DIV_EN undefined: N=7 -> 6'd0 after 2 cycles.
- Change A/B/N during CALC -> result reflects the captured values only; start pulsed during CALC is ignored.
